// File: rtl/rotor_stepper_if.sv
// Rotor stepper bus: load/keypress requests in, status and rotor positions out.
interface rotor_stepper_if #(
   parameter int W = 8
) ();
   logic         load;
   logic [W-1:0] load_l;
   logic [W-1:0] load_m;
   logic [W-1:0] load_r;
   logic         key_valid;
   logic         key_ready;
   logic         step_done;
   logic         load_err;
   logic         busy;
   logic [W-1:0] pos_l;
   logic [W-1:0] pos_m;
   logic [W-1:0] pos_r;

   // Requester side (keyboard / controller)
   modport master (
      output load, load_l, load_m, load_r, key_valid,
      input  key_ready, step_done, load_err, busy, pos_l, pos_m, pos_r
   );

   // Stepper side
   modport slave (
      input  load, load_l, load_m, load_r, key_valid,
      output key_ready, step_done, load_err, busy, pos_l, pos_m, pos_r
   );
endinterface

// File: rtl/rotor_stepper.sv
// Three-rotor position sequencer with notch / double-step behaviour.
// Rotor index 0 = right, 1 = middle, 2 = left.
module rotor_stepper #(
   parameter int ALPHA   = 26,
   parameter int W       = 8,
   parameter int NOTCH_R = 21,
   parameter int NOTCH_M = 4
) (
   input  logic           clk,
   input  logic           rst,
   rotor_stepper_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_STEP = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [W-1:0] LAST_POS  = W'(ALPHA - 1);
   localparam logic [W-1:0] ALPHA_W   = W'(ALPHA);
   localparam logic [W-1:0] NOTCH_R_W = W'(NOTCH_R);
   localparam logic [W-1:0] NOTCH_M_W = W'(NOTCH_M);

   state_t       r_state;
   state_t       w_state_next;
   logic [W-1:0] r_pos [3];
   logic [W-1:0] w_pos_next [3];
   logic [W-1:0] w_load_in [3];
   logic [W-1:0] w_inc [3];
   logic [2:0]   w_load_ok;
   logic [2:0]   w_adv;
   logic         r_load_err;
   logic         w_load_en;
   logic         w_step_en;
   logic         w_key_ready;
   logic         w_busy;
   logic         w_step_done;

   assign w_load_in[0] = bus.load_r;
   assign w_load_in[1] = bus.load_m;
   assign w_load_in[2] = bus.load_l;

   // Loads are only taken in IDLE; a step commits on the edge closing STEP.
   assign w_load_en = (r_state == S_IDLE) && bus.load;
   assign w_step_en = (r_state == S_STEP);

   // Advance enables, all from pre-step positions. The middle rotor also
   // advances when it sits on its own notch (the double-step anomaly).
   assign w_adv[0] = 1'b1;
   assign w_adv[1] = (r_pos[0] == NOTCH_R_W) || (r_pos[1] == NOTCH_M_W);
   assign w_adv[2] = (r_pos[1] == NOTCH_M_W);

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_rotor
         // Out-of-range load values are replaced by 0 for that rotor only.
         assign w_load_ok[gi] = (w_load_in[gi] < ALPHA_W);
         // Wrap by comparison rather than modulo: positions stay in 0..ALPHA-1.
         assign w_inc[gi] = (r_pos[gi] == LAST_POS) ? '0 : r_pos[gi] + W'(1);
         assign w_pos_next[gi] =
            w_load_en                 ? (w_load_ok[gi] ? w_load_in[gi] : '0) :
            (w_step_en && w_adv[gi])  ? w_inc[gi] :
                                        r_pos[gi];
      end
   endgenerate

   // State register; reset aborts any step in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state and handshake/status outputs.
   always_comb begin
      w_state_next = r_state;
      w_key_ready  = 1'b0;
      w_busy       = 1'b0;
      w_step_done  = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_key_ready = ~bus.load;
            if (bus.key_valid && !bus.load) begin
               w_state_next = S_STEP;
            end
         end
         S_STEP: begin
            w_busy       = 1'b1;
            w_state_next = S_DONE;
         end
         S_DONE: begin
            w_busy       = 1'b1;
            w_step_done  = 1'b1;
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // Rotor positions and the one-cycle load error flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 3; i++) begin
            r_pos[i] <= '0;
         end
         r_load_err <= 1'b0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            r_pos[i] <= w_pos_next[i];
         end
         r_load_err <= w_load_en && !(&w_load_ok);
      end
   end

   assign bus.key_ready = w_key_ready;
   assign bus.busy      = w_busy;
   assign bus.step_done = w_step_done;
   assign bus.load_err  = r_load_err;
   assign bus.pos_r     = r_pos[0];
   assign bus.pos_m     = r_pos[1];
   assign bus.pos_l     = r_pos[2];

endmodule

// File: tb/tb_rotor_stepper.sv
// Directed bench for rotor_stepper: expected post-step positions are queued
// when a keypress is driven and checked when step_done appears.
module tb_rotor_stepper;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   rotor_stepper_if #(.W(8)) bus ();

   rotor_stepper #(
      .ALPHA(26), .W(8), .NOTCH_R(21), .NOTCH_M(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct {
      logic [7:0] l;
      logic [7:0] m;
      logic [7:0] r;
   } pos_t;

   pos_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_pos(input string tag, input logic [7:0] l, input logic [7:0] m,
                          input logic [7:0] r);
      chk({tag, "_l"}, 32'(bus.pos_l), 32'(l));
      chk({tag, "_m"}, 32'(bus.pos_m), 32'(m));
      chk({tag, "_r"}, 32'(bus.pos_r), 32'(r));
   endtask

   task automatic do_load(input logic [7:0] l, input logic [7:0] m, input logic [7:0] r,
                          input logic [7:0] el, input logic [7:0] em, input logic [7:0] er,
                          input logic err);
      bus.load   = 1'b1;
      bus.load_l = l;
      bus.load_m = m;
      bus.load_r = r;
      @(posedge clk); #1;
      bus.load = 1'b0;
      chk("load_err_pulse", 32'(bus.load_err), 32'(err));
      chk_pos("load_pos", el, em, er);
      $display("[TB] load (%0d,%0d,%0d) -> pos (%0d,%0d,%0d) err=%0d",
               l, m, r, bus.pos_l, bus.pos_m, bus.pos_r, bus.load_err);
      @(posedge clk); #1;
      chk("load_err_clear", 32'(bus.load_err), 32'd0);
   endtask

   task automatic do_step(input logic [7:0] el, input logic [7:0] em, input logic [7:0] er);
      pos_t exp;
      int   cnt;
      exp.l = el; exp.m = em; exp.r = er;
      sb_q.push_back(exp);
      chk("key_ready_idle", 32'(bus.key_ready), 32'd1);
      bus.key_valid = 1'b1;
      @(posedge clk); #1;
      bus.key_valid = 1'b0;
      chk("busy_step", 32'(bus.busy), 32'd1);
      chk("key_ready_step", 32'(bus.key_ready), 32'd0);
      cnt = 0;
      while (bus.step_done !== 1'b1 && cnt < 8) begin
         @(posedge clk); #1;
         cnt++;
      end
      chk("done_latency", 32'(cnt), 32'd1);
      if (bus.step_done === 1'b1 && sb_q.size() > 0) begin
         exp = sb_q.pop_front();
         chk("key_ready_done", 32'(bus.key_ready), 32'd0);
         chk_pos("step_pos", exp.l, exp.m, exp.r);
      end
      $display("[TB] step -> pos (%0d,%0d,%0d) expected (%0d,%0d,%0d)",
               bus.pos_l, bus.pos_m, bus.pos_r, el, em, er);
      @(posedge clk); #1;
      chk("done_pulse_end", 32'(bus.step_done), 32'd0);
      chk("busy_idle", 32'(bus.busy), 32'd0);
   endtask

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst           = 1'b1;
      bus.load      = 1'b0;
      bus.load_l    = '0;
      bus.load_m    = '0;
      bus.load_r    = '0;
      bus.key_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state
      chk_pos("reset_pos", 8'd0, 8'd0, 8'd0);
      chk("reset_key_ready", 32'(bus.key_ready), 32'd1);
      chk("reset_busy", 32'(bus.busy), 32'd0);
      chk("reset_step_done", 32'(bus.step_done), 32'd0);
      chk("reset_load_err", 32'(bus.load_err), 32'd0);
      $display("[TB] reset -> pos (%0d,%0d,%0d)", bus.pos_l, bus.pos_m, bus.pos_r);

      // Plain step from home
      do_step(8'd0, 8'd0, 8'd1);

      // Right rotor on its notch carries the middle
      do_load(8'd0, 8'd0, 8'd21, 8'd0, 8'd0, 8'd21, 1'b0);
      do_step(8'd0, 8'd1, 8'd22);
      do_step(8'd0, 8'd1, 8'd23);

      // Double-step
      do_load(8'd0, 8'd3, 8'd21, 8'd0, 8'd3, 8'd21, 1'b0);
      do_step(8'd0, 8'd4, 8'd22);
      do_step(8'd1, 8'd5, 8'd23);

      // Wrap-around
      do_load(8'd25, 8'd4, 8'd25, 8'd25, 8'd4, 8'd25, 1'b0);
      do_step(8'd0, 8'd5, 8'd0);
      do_load(8'd25, 8'd25, 8'd25, 8'd25, 8'd25, 8'd25, 1'b0);
      do_step(8'd25, 8'd25, 8'd0);

      // Out-of-range loads
      do_load(8'd30, 8'd2, 8'd3, 8'd0, 8'd2, 8'd3, 1'b1);
      do_load(8'd0, 8'd26, 8'd25, 8'd0, 8'd0, 8'd25, 1'b1);

      // load and key_valid together: load wins, no step
      bus.load      = 1'b1;
      bus.key_valid = 1'b1;
      bus.load_l    = 8'd7;
      bus.load_m    = 8'd8;
      bus.load_r    = 8'd9;
      #1;
      chk("key_ready_during_load", 32'(bus.key_ready), 32'd0);
      @(posedge clk); #1;
      bus.load      = 1'b0;
      bus.key_valid = 1'b0;
      chk("load_vs_key_busy", 32'(bus.busy), 32'd0);
      chk_pos("load_vs_key_pos", 8'd7, 8'd8, 8'd9);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("load_vs_key_no_done", 32'(bus.step_done), 32'd0);
      end
      $display("[TB] load+key -> pos (%0d,%0d,%0d)", bus.pos_l, bus.pos_m, bus.pos_r);

      // load while busy is ignored without error
      do_load(8'd1, 8'd2, 8'd3, 8'd1, 8'd2, 8'd3, 1'b0);
      bus.key_valid = 1'b1;
      @(posedge clk); #1;
      bus.key_valid = 1'b0;
      bus.load      = 1'b1;
      bus.load_l    = 8'd40;
      bus.load_m    = 8'd9;
      bus.load_r    = 8'd9;
      @(posedge clk); #1;
      bus.load = 1'b0;
      chk("busy_load_done", 32'(bus.step_done), 32'd1);
      chk_pos("busy_load_pos", 8'd1, 8'd2, 8'd4);
      @(posedge clk); #1;
      chk("busy_load_no_err", 32'(bus.load_err), 32'd0);
      chk_pos("busy_load_hold", 8'd1, 8'd2, 8'd4);
      $display("[TB] load while busy -> pos (%0d,%0d,%0d)", bus.pos_l, bus.pos_m, bus.pos_r);

      // Reset asserted while in STEP
      bus.key_valid = 1'b1;
      @(posedge clk); #1;
      bus.key_valid = 1'b0;
      chk("abort_in_step", 32'(bus.busy), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk_pos("abort_pos", 8'd0, 8'd0, 8'd0);
      chk("abort_busy", 32'(bus.busy), 32'd0);
      chk("abort_no_done", 32'(bus.step_done), 32'd0);
      chk("abort_key_ready", 32'(bus.key_ready), 32'd1);
      @(posedge clk); #1;
      chk("abort_no_done_late", 32'(bus.step_done), 32'd0);
      $display("[TB] reset in STEP -> pos (%0d,%0d,%0d)", bus.pos_l, bus.pos_m, bus.pos_r);

      chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
